// File: rtl/sr_fetch_unit.sv
// Instruction fetch stage: PC, in-order imem requests, credit-limited instruction queue, redirect flush.
// Optional statistics counters are enabled by defining SR_FETCH_STATS_EN.
module sr_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned MAX_OUTST = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
`ifdef SR_FETCH_STATS_EN
    ,
    output logic [31:0] stat_fetched,
    output logic [31:0] stat_flushed,
    output logic [31:0] stat_stall
`endif
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW:0]   DEPTH_LIM = (CW + 1)'(DEPTH);
    localparam logic [CW-1:0] OUTST_LIM = CW'(MAX_OUTST);

    logic [31:0]   fetchPc;
    logic [31:0]   rspPc;
    logic [31:0]   qInstr [DEPTH];
    logic [31:0]   qPc    [DEPTH];
    logic [PW-1:0] rdPtr;
    logic [PW-1:0] wrPtr;
    logic [CW-1:0] count;
    logic [CW-1:0] outst;
    logic [CW-1:0] drop;
    logic [CW-1:0] outstNext;
    logic          accept;
    logic          push;
    logic          pop;
    logic          dropRsp;
    logic [31:0]   redirectTarget;

    assign redirectTarget = redirect_pc & ~32'h3;

    // Every accepted request owns a queue slot, so responses never need back-pressure.
    assign imem_req_valid = !rst && !redirect_valid
                            && (({1'b0, outst} + {1'b0, count}) < DEPTH_LIM)
                            && (outst < OUTST_LIM);
    assign imem_req_addr  = fetchPc;

    assign accept    = imem_req_valid && imem_req_ready;
    assign dropRsp   = imem_rsp_valid && (drop != '0);
    assign push      = imem_rsp_valid && (drop == '0) && !redirect_valid;
    assign pop       = instr_valid && instr_ready;
    assign outstNext = outst + CW'(accept) - CW'(imem_rsp_valid);

    assign instr_valid = (count != '0);
    assign instr       = instr_valid ? qInstr[rdPtr] : '0;
    assign instr_pc    = instr_valid ? qPc[rdPtr]    : '0;

    always_ff @(posedge clk) begin
        if (push) begin
            qInstr[wrPtr] <= imem_rsp_data;
            qPc[wrPtr]    <= rspPc;
        end
    end

    // rspPc tracks the PC of the next response that will be kept, so drops never advance it.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetchPc <= RESET_PC;
            rspPc   <= RESET_PC;
            rdPtr   <= '0;
            wrPtr   <= '0;
            count   <= '0;
            outst   <= '0;
            drop    <= '0;
        end else begin
            outst <= outstNext;
            if (redirect_valid) begin
                fetchPc <= redirectTarget;
                rspPc   <= redirectTarget;
                rdPtr   <= '0;
                wrPtr   <= '0;
                count   <= '0;
                drop    <= outstNext;
            end else begin
                if (accept)
                    fetchPc <= fetchPc + 32'd4;
                if (dropRsp)
                    drop <= drop - CW'(1);
                if (push) begin
                    wrPtr <= wrPtr + PW'(1);
                    rspPc <= rspPc + 32'd4;
                end
                if (pop)
                    rdPtr <= rdPtr + PW'(1);
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

`ifdef SR_FETCH_STATS_EN
    logic [CW:0] flushInc;

    // A redirect discards whatever the decoder did not take this cycle plus any word arriving now.
    always_comb begin
        flushInc = '0;
        if (redirect_valid)
            flushInc = {1'b0, count} - (CW + 1)'(pop) + (CW + 1)'(imem_rsp_valid);
        else if (dropRsp)
            flushInc = (CW + 1)'(1);
    end

    function automatic logic [31:0] satAdd(input logic [31:0] a, input logic [CW:0] b);
        logic [32:0] s;
        s = {1'b0, a} + 33'(b);
        return s[32] ? '1 : s[31:0];
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_fetched <= '0;
            stat_flushed <= '0;
            stat_stall   <= '0;
        end else begin
            if (push)
                stat_fetched <= satAdd(stat_fetched, (CW + 1)'(1));
            stat_flushed <= satAdd(stat_flushed, flushInc);
            if (instr_valid && !instr_ready)
                stat_stall <= satAdd(stat_stall, (CW + 1)'(1));
        end
    end
`endif

endmodule
